// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and field-layout helpers for the async FIFO write-side arbiter.
// Contents:
//   arb_state_e  - arbiter FSM states (IDLE, LOCK)
//   STALL_CNT_W  - width of the saturating full-stall counter
//   last_bit()   - bit position of the 'last' flag in a FIFO word
//   id_lsb()     - LSB position of the src_id field in a FIFO word
package async_fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned STALL_CNT_W = 16;

    // FIFO word layout is {last, src_id, payload}
    function automatic int unsigned last_bit(input int unsigned fifo_w);
        return fifo_w - 1;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned payload_w);
        return payload_w;
    endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_pick.sv
// Cyclic priority picker: finds the first set request bit at or after a
// starting pointer, wrapping around. Purely combinational.
// Ports:
//   i_req    [N-1:0]   request vector
//   i_ptr    [IW-1:0]  starting index (must be < N)
//   o_onehot [N-1:0]   one-hot of the chosen request, 0 if none
//   o_idx    [IW-1:0]  index of the chosen request, 0 if none
module rr_priority_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        o_onehot = '0;
        o_idx    = '0;
        found    = 1'b0;
        j        = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(i_ptr) + i) % N;
            if (!found && i_req[j]) begin
                found              = 1'b1;
                o_onehot[IW'(j)]   = 1'b1;
                o_idx              = IW'(j);
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing an async FIFO write port among NUM_REQ
// packet requesters in the wr_clk domain. The grant is held for a whole
// packet, but released after MAX_BURST beats so one long packet cannot
// starve the others. Every written word is {last, src_id, payload}.
// Ports:
//   wr_clk, rst_n            clock, async active-low reset
//   req_valid/last/data      per-requester beat interface (data packed i*PAYLOAD_W)
//   req_ready                per-requester accept (valid & ready = beat taken)
//   fifo_full/wr_en/data_in  FIFO write port
//   grant_onehot, busy       current grantee (0 when idle), LOCK state flag
//   stall_clr, stall_cnt     sync clear / saturating count of full-stalled cycles
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned PAYLOAD_W = 32,
    parameter  int unsigned MAX_BURST = 8,
    localparam int unsigned ID_W      = $clog2(NUM_REQ),
    localparam int unsigned FIFO_W    = PAYLOAD_W + ID_W + 1
) (
    input  logic                           wr_clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [FIFO_W-1:0]              fifo_data_in,
    output logic [NUM_REQ-1:0]             grant_onehot,
    output logic                           busy,
    input  logic                           stall_clr,
    output logic [STALL_CNT_W-1:0]         stall_cnt
);

    localparam int unsigned LAST_BIT = last_bit(FIFO_W);
    localparam int unsigned ID_LSB   = id_lsb(PAYLOAD_W);
    localparam int unsigned BC_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e             r_state;
    logic [ID_W-1:0]        r_gnt;
    logic [NUM_REQ-1:0]     r_gnt_oh;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [BC_W-1:0]        r_beat_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_lock;
    logic                   w_gnt_valid;
    logic                   w_gnt_last;
    logic [PAYLOAD_W-1:0]   w_gnt_data;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_stall;
    logic [NUM_REQ-1:0]     w_pick_oh;
    logic [ID_W-1:0]        w_pick_idx;

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    assign w_lock      = (r_state == LOCK);
    assign w_gnt_valid = req_valid[r_gnt];
    assign w_gnt_last  = req_last[r_gnt];
    assign w_gnt_data  = req_data[r_gnt*PAYLOAD_W +: PAYLOAD_W];

    // Beat moves in the same cycle it is presented; full blocks it entirely.
    assign w_accept  = w_lock & w_gnt_valid & ~fifo_full;
    assign w_release = w_accept & (w_gnt_last | (r_beat_cnt == BC_W'(MAX_BURST - 1)));
    assign w_stall   = w_lock & w_gnt_valid & fifo_full;

    assign fifo_wr_en   = w_accept;
    assign req_ready    = (w_lock && !fifo_full) ? r_gnt_oh : '0;
    assign grant_onehot = r_gnt_oh;
    assign busy         = w_lock;
    assign stall_cnt    = r_stall_cnt;

    always_comb begin
        fifo_data_in = '0;
        if (w_lock) begin
            fifo_data_in[LAST_BIT]           = w_gnt_last;
            fifo_data_in[ID_LSB +: ID_W]     = r_gnt;
            fifo_data_in[PAYLOAD_W-1:0]      = w_gnt_data;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_oh   <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_state    <= LOCK;
                        r_gnt      <= w_pick_idx;
                        r_gnt_oh   <= w_pick_oh;
                        r_beat_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (w_release) begin
                        r_state  <= IDLE;
                        r_gnt_oh <= '0;
                        r_rr_ptr <= (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter (NUM_REQ=4, PAYLOAD_W=32,
// MAX_BURST=8). Requesters are fed from per-requester beat queues; the
// expected write stream is derived from the round-robin/burst rules.
module tb_async_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int PW = 32;
    localparam int MB = 8;
    localparam int FW = PW + 2 + 1;

    logic            wr_clk = 1'b0;
    logic            rst_n  = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR*PW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [FW-1:0]   fifo_data_in;
    logic [NR-1:0]   grant_onehot;
    logic            busy;
    logic            stall_clr;
    logic [15:0]     stall_cnt;

    async_fifo_wr_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .MAX_BURST(MB)) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_onehot (grant_onehot),
        .busy         (busy),
        .stall_clr    (stall_clr),
        .stall_cnt    (stall_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW:0]   q[NR][$];      // {last, payload} beats waiting per requester
    logic [FW-1:0] wr_log[$];     // words actually written by the DUT
    logic [FW-1:0] exp_q[$];      // words the rules say should be written
    int            exp_grants;

    int            cyc;
    int            idle_cnt;
    logic          clr_drv;
    logic [15:0]   last_stall;
    logic          obs_wr[256];
    logic [FW-1:0] obs_data[256];
    logic [NR-1:0] obs_gnt[256];
    logic [NR-1:0] obs_ready[256];
    logic [15:0]   obs_stall[256];

    function automatic bit any_pending();
        for (int i = 0; i < NR; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected write stream: scan cyclically from the pointer for the next
    // requester with data, take up to MB beats or until its last beat.
    function automatic void build_expected();
        int idx[NR] = '{default: 0};
        int ptr = 0;
        int r;
        int n;
        bit lst;
        exp_q.delete();
        exp_grants = 0;
        while (1) begin
            r = -1;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (ptr + k) % NR;
                if (r < 0 && idx[c] < q[c].size()) r = c;
            end
            if (r < 0) break;
            n = 0;
            do begin
                lst = q[r][idx[r]][PW];
                exp_q.push_back({lst, 2'(r), q[r][idx[r]][PW-1:0]});
                idx[r]++;
                n++;
            end while (!lst && n < MB);
            ptr = (r + 1) % NR;
            exp_grants++;
        end
    endfunction

    task automatic push_packet(input int r, input int len);
        for (int b = 0; b < len; b++)
            q[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, $urandom()});
    endtask

    task automatic drive(input logic full);
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = q[i][0][PW];
                req_data[i*PW +: PW]  = q[i][0][PW-1:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*PW +: PW]  = '0;
            end
        end
        fifo_full = full;
        stall_clr = clr_drv;
    endtask

    // One clock: drive from queues, sample at negedge, pop accepted beats.
    task automatic step(input logic full);
        logic [NR-1:0] acc;
        drive(full);
        @(negedge wr_clk);
        acc = req_valid & req_ready;
        if (cyc < 256) begin
            obs_wr[cyc]    = fifo_wr_en;
            obs_data[cyc]  = fifo_data_in;
            obs_gnt[cyc]   = grant_onehot;
            obs_ready[cyc] = req_ready;
            obs_stall[cyc] = stall_cnt;
        end
        last_stall = stall_cnt;
        if (!busy) idle_cnt++;
        if (fifo_wr_en) wr_log.push_back(fifo_data_in);
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) void'(q[i].pop_front());
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        stall_clr = 1'b0;
        clr_drv   = 1'b0;
        for (int i = 0; i < NR; i++) q[i].delete();
        wr_log.delete();
        repeat (2) @(posedge wr_clk);
        #1 rst_n = 1'b1;
        cyc      = 0;
        idle_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_last  = '1;
        req_data  = '1;
        fifo_full = 1'b0;
        stall_clr = 1'b0;
        @(negedge wr_clk);
        n_tests += 6;
        if (fifo_wr_en !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
        if (fifo_data_in !== '0)      begin n_fail++; $display("FAIL reset_data: got %h expected 0", fifo_data_in); end
        if (grant_onehot !== '0)      begin n_fail++; $display("FAIL reset_grant: got %b expected 0", grant_onehot); end
        if (busy !== 1'b0)            begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (req_ready !== '0)         begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        if (stall_cnt !== 16'h0)      begin n_fail++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
    endtask

    task automatic test_single_packet();
        logic [PW-1:0] pl[3];
        apply_reset();
        pl[0] = 32'hA000_000A;
        pl[1] = 32'hB000_000B;
        pl[2] = 32'hC000_000C;
        for (int b = 0; b < 3; b++) q[1].push_back({(b == 2) ? 1'b1 : 1'b0, pl[b]});
        repeat (5) step(1'b0);
        n_tests += 4;
        if (obs_wr[0] !== 1'b0)       begin n_fail++; $display("FAIL single_idle_wr: got %b expected 0", obs_wr[0]); end
        if (obs_gnt[1] !== 4'b0010)   begin n_fail++; $display("FAIL single_grant: got %b expected 0010", obs_gnt[1]); end
        if (obs_wr[4] !== 1'b0)       begin n_fail++; $display("FAIL single_end_wr: got %b expected 0", obs_wr[4]); end
        if (obs_gnt[4] !== 4'b0000)   begin n_fail++; $display("FAIL single_end_grant: got %b expected 0", obs_gnt[4]); end
        for (int b = 0; b < 3; b++) begin
            logic [FW-1:0] e;
            e = {(b == 2) ? 1'b1 : 1'b0, 2'd1, pl[b]};
            n_tests += 2;
            if (obs_wr[b+1] !== 1'b1)  begin n_fail++; $display("FAIL single_wr%0d: got %b expected 1", b, obs_wr[b+1]); end
            if (obs_data[b+1] !== e)   begin n_fail++; $display("FAIL single_data%0d: got %h expected %h", b, obs_data[b+1], e); end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int r = 0; r < NR; r++) begin
            push_packet(r, 1);
            push_packet(r, 1);
        end
        repeat (10) step(1'b0);
        for (int k = 0; k < 10; k++) begin
            logic [NR-1:0] eg;
            logic          ew;
            eg = (k % 2 == 1) ? NR'(1 << ((k / 2) % NR)) : '0;
            ew = (k % 2 == 1);
            n_tests += 2;
            if (obs_gnt[k] !== eg) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", k, obs_gnt[k], eg); end
            if (obs_wr[k] !== ew)  begin n_fail++; $display("FAIL rr_wr c%0d: got %b expected %b", k, obs_wr[k], ew); end
        end
    endtask

    task automatic test_full_stall();
        logic [PW-1:0] last_pl;
        apply_reset();
        push_packet(2, 4);
        last_pl = q[2][3][PW-1:0];
        step(1'b0);
        step(1'b0);
        repeat (5) step(1'b1);
        repeat (4) step(1'b0);
        for (int k = 2; k < 7; k++) begin
            n_tests += 3;
            if (obs_wr[k] !== 1'b0)       begin n_fail++; $display("FAIL stall_wr c%0d: got %b expected 0", k, obs_wr[k]); end
            if (obs_ready[k] !== 4'b0)    begin n_fail++; $display("FAIL stall_ready c%0d: got %b expected 0", k, obs_ready[k]); end
            if (obs_gnt[k] !== 4'b0100)   begin n_fail++; $display("FAIL stall_grant c%0d: got %b expected 0100", k, obs_gnt[k]); end
        end
        n_tests += 4;
        if (obs_stall[7] !== 16'd5)   begin n_fail++; $display("FAIL stall_cnt: got %0d expected 5", obs_stall[7]); end
        if (wr_log.size() != 4)       begin n_fail++; $display("FAIL stall_words: got %0d expected 4", wr_log.size()); end
        if (obs_data[9] !== {1'b1, 2'd2, last_pl}) begin n_fail++; $display("FAIL stall_last: got %h expected %h", obs_data[9], {1'b1, 2'd2, last_pl}); end
        if (obs_wr[10] !== 1'b0)      begin n_fail++; $display("FAIL stall_end_wr: got %b expected 0", obs_wr[10]); end
    endtask

    task automatic test_burst_split();
        int n;
        apply_reset();
        push_packet(0, 20);
        push_packet(3, 3);
        build_expected();
        n = 0;
        while (any_pending() && n < 200) begin step(1'b0); n++; end
        n_tests += 4;
        if (any_pending())                begin n_fail++; $display("FAIL burst_timeout: got %0d cycles expected drain", n); end
        if (wr_log.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_words: got %0d expected %0d", wr_log.size(), exp_q.size()); end
        if (idle_cnt != exp_grants)       begin n_fail++; $display("FAIL burst_bubbles: got %0d expected %0d", idle_cnt, exp_grants); end
        if (wr_log.size() > 7 && wr_log[7][FW-1] !== 1'b0) begin n_fail++; $display("FAIL burst_split_last: got %b expected 0", wr_log[7][FW-1]); end
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            n_tests++;
            if (wr_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_word%0d: got %h expected %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midpacket();
        apply_reset();
        push_packet(0, 4);
        step(1'b0);
        step(1'b0);
        drive(1'b0);
        @(negedge wr_clk);
        n_tests++;
        if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_wr: got %b expected 1", fifo_wr_en); end
        #1 rst_n = 1'b0;
        #1;
        n_tests += 4;
        if (fifo_wr_en !== 1'b0)   begin n_fail++; $display("FAIL midrst_wr: got %b expected 0", fifo_wr_en); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (grant_onehot !== '0)   begin n_fail++; $display("FAIL midrst_grant: got %b expected 0", grant_onehot); end
        if (req_ready !== '0)      begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", req_ready); end
        for (int i = 0; i < NR; i++) q[i].delete();
        drive(1'b0);
        @(posedge wr_clk);
        #1 rst_n = 1'b1;
        cyc      = 0;
        idle_cnt = 0;
        wr_log.delete();
        push_packet(1, 1);
        push_packet(2, 1);
        repeat (4) step(1'b0);
        n_tests += 3;
        if (obs_gnt[1] !== 4'b0010)      begin n_fail++; $display("FAIL midrst_first: got %b expected 0010", obs_gnt[1]); end
        if (obs_gnt[3] !== 4'b0100)      begin n_fail++; $display("FAIL midrst_second: got %b expected 0100", obs_gnt[3]); end
        if (obs_data[1][PW+1:PW] !== 2'd1) begin n_fail++; $display("FAIL midrst_id: got %0d expected 1", obs_data[1][PW+1:PW]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n;
            apply_reset();
            for (int r = 0; r < NR; r++) begin
                int np;
                np = $urandom_range(3);
                for (int p = 0; p < np; p++) push_packet(r, $urandom_range(20, 1));
            end
            if (!any_pending()) push_packet($urandom_range(NR - 1), 5);
            build_expected();
            n = 0;
            while (any_pending() && n < 4000) begin
                step(($urandom_range(99) < 30) ? 1'b1 : 1'b0);
                n++;
            end
            n_tests += 3;
            if (any_pending())                 begin n_fail++; $display("FAIL rand%0d_timeout: got %0d cycles expected drain", it, n); end
            if (wr_log.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_words: got %0d expected %0d", it, wr_log.size(), exp_q.size()); end
            if (idle_cnt != exp_grants)        begin n_fail++; $display("FAIL rand%0d_bubbles: got %0d expected %0d", it, idle_cnt, exp_grants); end
            for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
                n_tests++;
                if (wr_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d: got %h expected %h", it, i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_stall_saturate();
        apply_reset();
        push_packet(0, 1);
        repeat (70000) step(1'b1);
        n_tests += 2;
        if (obs_stall[10] !== 16'd9)   begin n_fail++; $display("FAIL sat_early: got %0d expected 9", obs_stall[10]); end
        if (last_stall !== 16'hFFFF)   begin n_fail++; $display("FAIL sat_value: got %h expected ffff", last_stall); end
        clr_drv = 1'b1;
        step(1'b1);
        clr_drv = 1'b0;
        step(1'b1);
        n_tests++;
        if (last_stall !== 16'h0)      begin n_fail++; $display("FAIL sat_clear: got %h expected 0", last_stall); end
        step(1'b1);
        n_tests++;
        if (last_stall !== 16'h1)      begin n_fail++; $display("FAIL sat_restart: got %h expected 1", last_stall); end
        step(1'b0);
        n_tests++;
        if (wr_log.size() != 1)        begin n_fail++; $display("FAIL sat_drain: got %0d expected 1", wr_log.size()); end
    endtask

    initial begin
        clr_drv = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_burst_split();
        test_reset_midpacket();
        test_random();
        test_stall_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
